// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_e;

    localparam int unsigned SUB_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full-adder cell; the caller inverts b so the cell computes a + ~b + cin.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (Diff = A - B, LSB first) with valid/ready on both sides.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    sub_state_e       state;
    sub_state_e       state_d;
    logic             in_ready_d;
    logic             out_valid_d;
    logic             accept_c;
    logic             last_c;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic [WIDTH-1:0] d_next_c;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cell_s;
    logic             cell_cout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_sub_cell u_cell (
        .a    (a_sh[0]),
        .b    (~b_sh[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the word is complete.
    assign d_next_c = {cell_s, d_sh};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        last_c   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // Operand/result datapath; results are published only on the final shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Ovf    <= 1'b0;
`endif
        end else if (accept_c) begin
            a_sh  <= A;
            b_sh  <= B;
            d_sh  <= '0;
            carry <= 1'b1;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            d_sh  <= d_next_c[WIDTH-1:1];
            carry <= cell_cout;
            cnt   <= cnt + CNT_W'(1);
            if (last_c) begin
                Diff   <= d_next_c;
                Borrow <= ~cell_cout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                Ovf    <= (a_msb != b_msb) & (cell_s != a_msb);
`endif
            end
        end
    end

endmodule
